// File: rtl/sdram_rd_fifo_ctrl.sv
// ============================================================================
// sdram_rd_fifo_ctrl
// ----------------------------------------------------------------------------
// This block issues burst requests to the SDRAM full-page read engine and
// collects the returned words in a single-clock first-word-fall-through FIFO.
// The FIFO is drained by the user side.
//
// A new burst is requested only when the FIFO has room for a whole burst, so
// read data is never dropped. Requests walk a linear window
// [rd_base_addr, rd_end_addr) one burst at a time. A request wraps back to
// the base when the next burst would not fit in the window.
//
// Ports
//   clk, rst        system clock; asynchronous active-high reset
//   rd_start        level; enables read streaming
//   rd_flush        pulse; empties the FIFO and reloads the address to base
//   rd_base_addr    window start {bank[1:0],row[12:0],col[8:0]}
//   rd_end_addr     window end (exclusive)
//   rd_en           burst request to the read engine
//   rd_addr         burst start address
//   rd_burst_len    burst length (constant BURST_LEN)
//   rd_ack          read engine data-valid strobe
//   rd_data         read engine data, qualified by rd_ack
//   rd_end          one-cycle pulse when the engine's burst has finished
//   fifo_rd_en      user pop
//   fifo_rd_data    FIFO head word (0 when empty)
//   fifo_empty      FIFO empty flag
//   fifo_count      number of words stored
// ============================================================================
module sdram_rd_fifo_ctrl #(
    parameter int BURST_LEN  = 256,
    parameter int FIFO_DEPTH = 1024,
    parameter int FIFO_AW    = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_start,
    input  logic               rd_flush,
    input  logic [23:0]        rd_base_addr,
    input  logic [23:0]        rd_end_addr,
    output logic               rd_en,
    output logic [23:0]        rd_addr,
    output logic [9:0]         rd_burst_len,
    input  logic               rd_ack,
    input  logic [15:0]        rd_data,
    input  logic               rd_end,
    input  logic               fifo_rd_en,
    output logic [15:0]        fifo_rd_data,
    output logic               fifo_empty,
    output logic [FIFO_AW:0]   fifo_count
);

    localparam int            CW       = FIFO_AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] BURST_C  = CW'(BURST_LEN);
    localparam logic [10:0]   BURST_WC = 11'(BURST_LEN);
    localparam logic [23:0]   BURST_A  = 24'(BURST_LEN);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_END
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [CW-1:0]   wr_ptr;
    logic [CW-1:0]   rd_ptr;
    logic [15:0]     mem [FIFO_DEPTH];
    logic [10:0]     word_cnt;
    logic            flush_pend;
    logic            addr_loaded;

    logic            fifo_full;
    logic            accept;
    logic            push;
    logic            pop;
    logic            do_flush;
    logic [CW-1:0]   free_words;
    logic [23:0]     addr_step;
    logic [23:0]     addr_step_end;

    // Pointers carry one extra bit so that full and empty can be told apart.
    // The count is simply their difference.
    assign fifo_count = wr_ptr - rd_ptr;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (fifo_count == DEPTH_C);

    // No burst is in flight while in IDLE, so the pending word count is zero.
    // The free space is then just the unused FIFO depth.
    assign free_words = DEPTH_C - fifo_count;

    // Words past BURST_LEN in a single burst are ignored.
    assign accept = rd_ack && (word_cnt < BURST_WC);

    // A flush outside IDLE is held back until the in-flight burst ends.
    // This keeps the engine's remaining words from landing in a fresh FIFO.
    assign do_flush = (state == IDLE) ? rd_flush
                                      : (rd_end && (flush_pend || rd_flush));

    assign push = accept && !fifo_full && !do_flush;
    assign pop  = fifo_rd_en && !fifo_empty && !do_flush;

    assign rd_burst_len = 10'(BURST_LEN);
    assign fifo_rd_data = fifo_empty ? 16'd0 : mem[rd_ptr[FIFO_AW-1:0]];

    // The wrap test is done on the address after the step.
    // A burst starting there must end at or before rd_end_addr.
    assign addr_step     = rd_addr + BURST_A;
    assign addr_step_end = addr_step + BURST_A;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and request decode.
    // rd_en stays high for the whole burst, including the rd_end cycle.
    // So it drops on the cycle after rd_end.
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        case (state)
            IDLE: begin
                if (rd_start && (free_words >= BURST_C)) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                rd_en = 1'b1;
                if (rd_end) begin
                    state_nxt = IDLE;
                end else if (rd_ack) begin
                    state_nxt = WAIT_END;
                end
            end
            WAIT_END: begin
                rd_en = 1'b1;
                if (rd_end) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Counts the words accepted in the current burst; rd_end closes the burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt <= 11'd0;
        end else if (rd_end) begin
            word_cnt <= 11'd0;
        end else if (accept) begin
            word_cnt <= word_cnt + 11'd1;
        end
    end

    // Remembers a flush that arrived while a burst was still running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_pend <= 1'b0;
        end else if (state == IDLE || rd_end) begin
            flush_pend <= 1'b0;
        end else if (rd_flush) begin
            flush_pend <= 1'b1;
        end
    end

    // The burst address register.
    // It loads the base once after reset, reloads it on a flush, and steps
    // through the window at the end of each burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr     <= 24'd0;
            addr_loaded <= 1'b0;
        end else if (!addr_loaded) begin
            rd_addr     <= rd_base_addr;
            addr_loaded <= 1'b1;
        end else if (do_flush) begin
            rd_addr <= rd_base_addr;
        end else if ((state != IDLE) && rd_end) begin
            if (addr_step_end > rd_end_addr) begin
                rd_addr <= rd_base_addr;
            end else begin
                rd_addr <= addr_step;
            end
        end
    end

    // The FIFO pointers.
    // A flush discards any push or pop in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (do_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // The FIFO storage.
    // It is not reset, because the head is masked to zero while the FIFO is
    // empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= rd_data;
        end
    end

endmodule

// File: tb/tb_sdram_rd_fifo_ctrl.sv
// ============================================================================
// tb_sdram_rd_fifo_ctrl
// ----------------------------------------------------------------------------
// Testbench for sdram_rd_fifo_ctrl.
// It stands in for the read engine and the user side.
// A queue-based model of the FIFO and address window supplies the expected
// value of every output on every cycle.
// ============================================================================
module tb_sdram_rd_fifo_ctrl;

    localparam int BL    = 256;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_start;
    logic          rd_flush;
    logic [23:0]   rd_base_addr;
    logic [23:0]   rd_end_addr;
    logic          rd_en;
    logic [23:0]   rd_addr;
    logic [9:0]    rd_burst_len;
    logic          rd_ack;
    logic [15:0]   rd_data;
    logic          rd_end;
    logic          fifo_rd_en;
    logic [15:0]   fifo_rd_data;
    logic          fifo_empty;
    logic [AW:0]   fifo_count;

    sdram_rd_fifo_ctrl #(
        .BURST_LEN  (BL),
        .FIFO_DEPTH (DEPTH),
        .FIFO_AW    (AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rd_start     (rd_start),
        .rd_flush     (rd_flush),
        .rd_base_addr (rd_base_addr),
        .rd_end_addr  (rd_end_addr),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_burst_len (rd_burst_len),
        .rd_ack       (rd_ack),
        .rd_data      (rd_data),
        .rd_end       (rd_end),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .fifo_count   (fifo_count)
    );

    always #5 clk = ~clk;

    int          tests_run    = 0;
    int          tests_failed = 0;
    bit          chk_en       = 1'b0;
    longint      last_req_addr;
    logic [15:0] popped[$];

    // Model state: FIFO contents, burst in flight, address window position.
    logic [15:0] mq[$];
    bit          m_busy;
    bit          m_flush_wait;
    bit          m_addr_valid;
    int          m_got;
    int          m_addr;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model, advanced once per clock from the inputs it sees.
    always @(posedge clk or posedge rst) begin : model
        bit was_full;
        bit take;
        bit pop_now;
        bit flush_now;
        bit start_now;
        int nxt;
        if (rst) begin
            mq.delete();
            m_busy       = 1'b0;
            m_flush_wait = 1'b0;
            m_addr_valid = 1'b0;
            m_got        = 0;
            m_addr       = 0;
        end else begin
            was_full  = (mq.size() == DEPTH);
            pop_now   = fifo_rd_en && (mq.size() > 0);
            take      = rd_ack && (m_got < BL);
            start_now = !m_busy && rd_start && ((DEPTH - mq.size()) >= BL);
            flush_now = m_busy ? (rd_end && (m_flush_wait || rd_flush)) : rd_flush;

            if (take) begin
                checkOutput("push_while_full", longint'(was_full), 0);
            end
            if (flush_now) begin
                mq.delete();
            end else begin
                if (pop_now) begin
                    void'(mq.pop_front());
                end
                if (take && !was_full) begin
                    mq.push_back(rd_data);
                end
            end

            if (!m_addr_valid) begin
                m_addr       = int'(rd_base_addr);
                m_addr_valid = 1'b1;
            end else if (flush_now) begin
                m_addr = int'(rd_base_addr);
            end else if (m_busy && rd_end) begin
                nxt = (m_addr + BL) % 16777216;
                if (((nxt + BL) % 16777216) > int'(rd_end_addr)) begin
                    m_addr = int'(rd_base_addr);
                end else begin
                    m_addr = nxt;
                end
            end

            if (m_busy) begin
                m_flush_wait = rd_end ? 1'b0 : (m_flush_wait || rd_flush);
            end else begin
                m_flush_wait = 1'b0;
            end

            if (rd_end) begin
                m_got = 0;
            end else if (take) begin
                m_got++;
            end

            if (m_busy) begin
                if (rd_end) begin
                    m_busy = 1'b0;
                end
            end else if (start_now) begin
                m_busy = 1'b1;
            end
        end
    end

    // Every output is compared with the model shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            checkOutput("rd_en", longint'(rd_en), longint'(m_busy));
            checkOutput("rd_addr", longint'(rd_addr), longint'(m_addr));
            checkOutput("fifo_count", longint'(fifo_count), longint'(mq.size()));
            checkOutput("fifo_empty", longint'(fifo_empty), longint'(mq.size() == 0));
            checkOutput("fifo_rd_data", longint'(fifo_rd_data),
                        (mq.size() == 0) ? 0 : longint'(mq[0]));
            checkOutput("rd_burst_len", longint'(rd_burst_len), BL);
        end
    end

    // Plays the read engine for one burst.
    // pop_mode: 0 = no pops, 1 = pop on every ack cycle, 2 = random pops and
    // flushes.
    // flush_at / stop_at: the ack index that pulses rd_flush or drops
    // rd_start (-1 = never).
    task automatic applyStimulus(input int n_acks, input int data_base, input bit gappy,
                                 input int pop_mode, input int flush_at, input int stop_at);
        int budget;
        int i;
        int lat;
        budget        = 4000;
        last_req_addr = -1;
        while (rd_en !== 1'b1 && budget > 0) begin
            fifo_rd_en = (pop_mode == 2) && ($urandom_range(0, 1) == 1);
            rd_flush   = (pop_mode == 2) && ($urandom_range(0, 63) == 0);
            @(negedge clk);
            budget--;
        end
        fifo_rd_en = 1'b0;
        rd_flush   = 1'b0;
        if (rd_en !== 1'b1) begin
            checkOutput("request_timeout", 0, 1);
            return;
        end
        last_req_addr = longint'(rd_addr);
        lat = $urandom_range(0, 3);
        repeat (lat) begin
            fifo_rd_en = (pop_mode == 2) && ($urandom_range(0, 1) == 1);
            @(negedge clk);
        end
        i = 0;
        while (i < n_acks) begin
            if (gappy && ($urandom_range(0, 3) == 0)) begin
                rd_ack = 1'b0;
            end else begin
                rd_ack  = 1'b1;
                rd_data = 16'(data_base + i);
                if (i == flush_at) rd_flush = 1'b1;
                if (i == stop_at) rd_start = 1'b0;
                i++;
            end
            if (pop_mode == 1) begin
                fifo_rd_en = rd_ack;
                if (rd_ack) popped.push_back(fifo_rd_data);
            end else begin
                fifo_rd_en = (pop_mode == 2) && ($urandom_range(0, 1) == 1);
            end
            @(negedge clk);
            rd_flush = 1'b0;
        end
        rd_ack     = 1'b0;
        rd_end     = 1'b1;
        fifo_rd_en = (pop_mode == 2) && ($urandom_range(0, 1) == 1);
        @(negedge clk);
        rd_end     = 1'b0;
        fifo_rd_en = 1'b0;
    endtask

    task automatic drainWords(input int n);
        repeat (n) begin
            fifo_rd_en = 1'b1;
            @(negedge clk);
        end
        fifo_rd_en = 1'b0;
    endtask

    initial begin
        int budget;
        int bad;
        rst          = 1'b0;
        rd_start     = 1'b0;
        rd_flush     = 1'b0;
        rd_base_addr = 24'h000000;
        rd_end_addr  = 24'h000400;
        rd_ack       = 1'b0;
        rd_data      = 16'd0;
        rd_end       = 1'b0;
        fifo_rd_en   = 1'b0;
        #1;
        rst    = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_rd_en", longint'(rd_en), 0);
        checkOutput("reset_fifo_empty", longint'(fifo_empty), 1);
        checkOutput("reset_fifo_count", longint'(fifo_count), 0);
        checkOutput("reset_fifo_rd_data", longint'(fifo_rd_data), 0);
        checkOutput("reset_rd_addr", longint'(rd_addr), 0);
        rst      = 1'b0;
        rd_start = 1'b1;

        // First burst fills 256 words from address 0.
        applyStimulus(256, 0, 1'b0, 0, -1, -1);
        checkOutput("t1_req_addr", last_req_addr, 24'h000000);
        checkOutput("t1_fifo_count", longint'(fifo_count), 256);

        // No pops: three more bursts, then the full FIFO blocks requests.
        applyStimulus(256, 256, 1'b1, 0, -1, -1);
        checkOutput("t2_req_addr_1", last_req_addr, 24'h000100);
        applyStimulus(256, 512, 1'b1, 0, -1, -1);
        checkOutput("t2_req_addr_2", last_req_addr, 24'h000200);
        applyStimulus(256, 768, 1'b1, 0, -1, -1);
        checkOutput("t2_req_addr_3", last_req_addr, 24'h000300);
        repeat (16) @(negedge clk);
        checkOutput("t2_full_no_request", longint'(rd_en), 0);
        checkOutput("t2_full_count", longint'(fifo_count), 1024);
        drainWords(256);
        applyStimulus(256, 1024, 1'b1, 0, -1, -1);
        checkOutput("t2_wrap_addr", last_req_addr, 24'h000000);
        drainWords(256);

        // Flush mid-burst is held until rd_end.
        applyStimulus(256, 4096, 1'b0, 0, 100, -1);
        checkOutput("t5_req_addr", last_req_addr, 24'h000100);
        checkOutput("t5_flush_count", longint'(fifo_count), 0);
        checkOutput("t5_flush_empty", longint'(fifo_empty), 1);
        checkOutput("t5_flush_addr", longint'(rd_addr), 24'h000000);

        // Overlong burst: only 256 words are kept.
        applyStimulus(260, 0, 1'b1, 0, -1, -1);
        checkOutput("t3_req_addr", last_req_addr, 24'h000000);
        checkOutput("t3_fifo_count", longint'(fifo_count), 256);

        // Push and pop together: the count holds and the ramp 0..255 comes out.
        popped.delete();
        applyStimulus(256, 1000, 1'b0, 1, -1, -1);
        checkOutput("t4_req_addr", last_req_addr, 24'h000100);
        checkOutput("t4_fifo_count", longint'(fifo_count), 256);
        checkOutput("t4_popped_words", longint'(popped.size()), 256);
        bad = 0;
        for (int k = 0; k < popped.size(); k++) begin
            if (popped[k] != 16'(k)) bad++;
        end
        checkOutput("t4_ramp_order", bad, 0);

        // rd_start drops mid-burst: the burst completes and no new request follows.
        applyStimulus(256, 2000, 1'b1, 0, -1, 50);
        checkOutput("stop_req_addr", last_req_addr, 24'h000200);
        repeat (10) @(negedge clk);
        checkOutput("stop_no_request", longint'(rd_en), 0);
        checkOutput("stop_fifo_count", longint'(fifo_count), 512);
        rd_start = 1'b1;

        // Reset in the middle of a burst.
        budget = 50;
        while (rd_en !== 1'b1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checkOutput("t6_request_seen", longint'(rd_en), 1);
        for (int k = 0; k < 40; k++) begin
            rd_ack  = 1'b1;
            rd_data = 16'(k);
            @(negedge clk);
        end
        rd_ack = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        checkOutput("t6_rd_en", longint'(rd_en), 0);
        checkOutput("t6_fifo_empty", longint'(fifo_empty), 1);
        checkOutput("t6_fifo_count", longint'(fifo_count), 0);
        checkOutput("t6_rd_addr", longint'(rd_addr), 0);
        rd_base_addr = 24'h1F0000;
        rd_end_addr  = 24'h1F0380;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_base_load", longint'(rd_addr), 24'h1F0000);

        // Random bursts in a window that is not a multiple of the burst size.
        for (int b = 0; b < 12; b++) begin
            applyStimulus(($urandom_range(0, 3) == 0) ? (BL + $urandom_range(1, 4)) : BL,
                          int'($urandom_range(0, 65535)), 1'b1, 2,
                          ($urandom_range(0, 4) == 0) ? $urandom_range(1, 200) : -1, -1);
        end

        rd_start   = 1'b0;
        fifo_rd_en = 1'b0;
        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
